// File: rtl/sram_arb_pkg.sv
// Shared types for the external SRAM arbiter: FSM states, requester ids and the latched request payload.
package sram_arb_pkg;

    localparam int unsigned ARB_AW = 20;
    localparam int unsigned ARB_DW = 16;
    localparam int unsigned ARB_BE = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOV
    } state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_e;

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
        logic [ARB_BE-1:0] be;
    } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (adv && (gnt != 2'b00)) begin
            last_d = gnt[1] ? REQ_B : REQ_A;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between requesters A and B; sequences the strobes for one access at a time.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW       = ARB_AW,
    parameter int unsigned DW       = ARB_DW,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [1:0]    a_be,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic [1:0]    b_be,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_dq_i,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n
);

    localparam int unsigned CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYC must be >= 1");
    end
    if ((AW > ARB_AW) || (DW > ARB_DW)) begin : g_bad_width
        $error("sram_arbiter: AW/DW exceed the request payload width");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    sram_req_t       req_q, req_d;
    req_id_e         owner_q, owner_d;

    logic            a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic            a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DW-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dq_o_q, dq_o_d;
    logic            dq_oe_q, dq_oe_d;
    logic            ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic            lb_n_q, lb_n_d, ub_n_q, ub_n_d;

    logic [1:0]      arb_gnt;
    logic            arb_adv;
    sram_req_t       a_fields, b_fields, sel, acc;
    logic            acc_on;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({b_req, a_req}),
        .adv     (arb_adv),
        .gnt     (arb_gnt)
    );

    always_comb begin
        a_fields.we    = a_we;
        a_fields.addr  = ARB_AW'(a_addr);
        a_fields.wdata = ARB_DW'(a_wdata);
        a_fields.be    = a_be;
        b_fields.we    = b_we;
        b_fields.addr  = ARB_AW'(b_addr);
        b_fields.wdata = ARB_DW'(b_wdata);
        b_fields.be    = b_be;
        sel            = arb_gnt[1] ? b_fields : a_fields;
    end

    // Next-state and registered-output logic; strobes idle high unless an access is active.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        owner_d    = owner_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = 1'b0;
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        lb_n_d     = 1'b1;
        ub_n_d     = 1'b1;
        arb_adv    = 1'b0;
        acc        = req_q;
        acc_on     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    arb_adv = 1'b1;
                    a_gnt_d = arb_gnt[0];
                    b_gnt_d = arb_gnt[1];
                    owner_d = arb_gnt[1] ? REQ_B : REQ_A;
                    req_d   = sel;
                    cnt_d   = CW'(WAIT_CYC - 1);
                    state_d = ACCESS;
                    acc     = sel;
                    acc_on  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CW'(1);
                    acc_on = 1'b1;
                end else begin
                    state_d = RECOV;
                    // Write data stays on the bus through recovery for hold time.
                    dq_oe_d = req_q.we;
                    if (!req_q.we) begin
                        if (owner_q == REQ_B) begin
                            b_rvalid_d = 1'b1;
                            b_rdata_d  = sram_dq_i;
                        end else begin
                            a_rvalid_d = 1'b1;
                            a_rdata_d  = sram_dq_i;
                        end
                    end
                end
            end
            RECOV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (acc_on) begin
            addr_d  = AW'(acc.addr);
            ce_n_d  = 1'b0;
            lb_n_d  = ~acc.be[0];
            ub_n_d  = ~acc.be[1];
            we_n_d  = ~acc.we;
            oe_n_d  = acc.we;
            dq_oe_d = acc.we;
            if (acc.we) begin
                dq_o_d = DW'(acc.wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            owner_q    <= REQ_A;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            owner_q    <= owner_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
        end
    end

    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_lb_n  = lb_n_q;
    assign sram_ub_n  = ub_n_q;

endmodule
